// File: rtl/refill_if.sv
// Refill bus bundle: both cache miss ports plus the shared memory read port.
// master = arbiter side, slave = caches/memory side.
interface refill_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ic_miss;
   logic [ADDR_W-1:0] ic_addr;
   logic [DATA_W-1:0] ic_data;
   logic              ic_ready;
   logic              dc_miss;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_data;
   logic              dc_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      input  ic_miss, ic_addr, dc_miss, dc_addr, mem_rdata, mem_ack,
      output ic_data, ic_ready, dc_data, dc_ready, mem_req, mem_addr
   );

   modport slave (
      output ic_miss, ic_addr, dc_miss, dc_addr, mem_rdata, mem_ack,
      input  ic_data, ic_ready, dc_data, dc_ready, mem_req, mem_addr
   );
endinterface

// File: rtl/refill_arbiter.sv
// Round-robin refill arbiter: icache (req 0) and dcache (req 1) share one memory read port.
// Optional REFILL_TIMEOUT_EN aborts a stalled memory request and returns ERR_DATA.
module refill_arbiter #(
   parameter int                 ADDR_W         = 32,
   parameter int                 DATA_W         = 32,
   parameter int                 TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]  ERR_DATA       = 32'h00000013
) (
   input  logic     clk,
   input  logic     reset,
   refill_if.master bus,
   output logic     busy,
   output logic     timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state_q, state_nx;
   logic              grant_q, grant_nx;
   logic              last_q, last_nx;
   logic              req_q, req_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic [DATA_W-1:0] ic_data_q, ic_data_nx;
   logic [DATA_W-1:0] dc_data_q, dc_data_nx;
   logic              ic_rdy_q, ic_rdy_nx;
   logic              dc_rdy_q, dc_rdy_nx;
   logic              busy_q, busy_nx;
   logic              done;
   logic [DATA_W-1:0] word;

`ifdef REFILL_TIMEOUT_EN
   logic [7:0]        cnt_q, cnt_nx;
   logic              terr_q, terr_nx;
`endif

   // Address LSBs and (in the default build) the timeout parameters are intentionally unused.
   logic unused_cfg;
   assign unused_cfg = ^{bus.ic_addr[1:0], bus.dc_addr[1:0], ERR_DATA, 8'(TIMEOUT_CYCLES)};

   always_comb begin
      state_nx   = state_q;
      grant_nx   = grant_q;
      last_nx    = last_q;
      req_nx     = req_q;
      addr_nx    = addr_q;
      ic_data_nx = ic_data_q;
      dc_data_nx = dc_data_q;
      ic_rdy_nx  = 1'b0;
      dc_rdy_nx  = 1'b0;
      done       = 1'b0;
      word       = bus.mem_rdata;
`ifdef REFILL_TIMEOUT_EN
      cnt_nx     = cnt_q;
      terr_nx    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.ic_miss || bus.dc_miss) begin
               // On a tie the requester that was not served last wins.
               grant_nx = (bus.ic_miss && bus.dc_miss) ? ~last_q : bus.dc_miss;
               addr_nx  = grant_nx ? {bus.dc_addr[ADDR_W-1:2], 2'b00}
                                   : {bus.ic_addr[ADDR_W-1:2], 2'b00};
               req_nx   = 1'b1;
               state_nx = ISSUE;
`ifdef REFILL_TIMEOUT_EN
               cnt_nx   = 8'd0;
`endif
            end
         end
         ISSUE: begin
            if (bus.mem_ack) begin
               done = 1'b1;
`ifdef REFILL_TIMEOUT_EN
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               done    = 1'b1;
               word    = ERR_DATA;
               terr_nx = 1'b1;
            end else begin
               cnt_nx  = cnt_q + 8'd1;
`endif
            end
            if (done) begin
               req_nx   = 1'b0;
               state_nx = RESP;
               if (grant_q) begin
                  dc_data_nx = word;
                  dc_rdy_nx  = 1'b1;
               end else begin
                  ic_data_nx = word;
                  ic_rdy_nx  = 1'b1;
               end
            end
         end
         RESP: begin
            last_nx  = grant_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         req_q     <= 1'b0;
         addr_q    <= '0;
         ic_data_q <= '0;
         dc_data_q <= '0;
         ic_rdy_q  <= 1'b0;
         dc_rdy_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_nx;
         grant_q   <= grant_nx;
         last_q    <= last_nx;
         req_q     <= req_nx;
         addr_q    <= addr_nx;
         ic_data_q <= ic_data_nx;
         dc_data_q <= dc_data_nx;
         ic_rdy_q  <= ic_rdy_nx;
         dc_rdy_q  <= dc_rdy_nx;
         busy_q    <= busy_nx;
      end
   end

`ifdef REFILL_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 8'd0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_nx;
         terr_q <= terr_nx;
      end
   end
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign bus.mem_req  = req_q;
   assign bus.mem_addr = addr_q;
   assign bus.ic_data  = ic_data_q;
   assign bus.ic_ready = ic_rdy_q;
   assign bus.dc_data  = dc_data_q;
   assign bus.dc_ready = dc_rdy_q;
   assign busy         = busy_q;

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Shares one backing-memory read port between the instruction-cache miss path (requester 0) and the data-cache miss path (requester 1).
- Each requester raises a miss with a word address and holds it until it receives a one-cycle ready pulse carrying the fetched word.
- Arbitration is round-robin, and one memory transaction is outstanding at a time.
- Sits between icache_dm (its fetchaddr/miss outputs drive ic_addr/ic_miss; ic_data/ic_ready feed its ifetch/iready) and the memory model/bus.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 255, cycles mem_req may wait for mem_ack before abort (used only with the optional feature; range 1..255).
- ERR_DATA, 32'h00000013, word returned on timeout (RV32 NOP).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ic_miss  in  1  requester 0 request; held until ic_ready.
- ic_addr  in  ADDR_W  requester 0 address; bits [1:0] ignored.
- ic_data  out  DATA_W  word returned to requester 0.
- ic_ready  out  1  one-cycle pulse; ic_data valid.
- dc_miss  in  1  requester 1 request.
- dc_addr  in  ADDR_W  requester 1 address.
- dc_data  out  DATA_W  word returned to requester 1.
- dc_ready  out  1  one-cycle pulse; dc_data valid.
- mem_req  out  1  memory read request, held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned address, stable while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  memory completion strobe.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  one-cycle pulse on abort (tied 0 without the optional feature).

Behaviour:
- Reset: all outputs 0, state=IDLE, last_grant=1 (so IC wins the first tie), latched address/data = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any miss is high, pick a winner. With both high, the winner is the requester not equal to last_grant; otherwise the sole requester wins.
  - Latch grant and {addr[ADDR_W-1:2],2'b00}, then go to ISSUE. mem_req rises and mem_addr is valid in the next cycle.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_req=1 and mem_addr are held constant.
  - mem_ack is sampled each cycle. When it is high, capture mem_rdata, clear mem_req on the next edge, and go to RESP.
- RESP:
  - The winner's ready=1 for exactly this cycle, and its data = captured word. The other requester's ready stays 0.
  - The data output keeps its value until the next response to that requester.
  - last_grant <= winner. Return to IDLE; no arbitration happens in RESP.
- Latency: request first seen high in IDLE at cycle N, ack at the earliest cycle N+1 → ready at N+2. A back-to-back second grant gets mem_req at N+4.
- A requester dropping its miss mid-transaction does not cancel the transaction. The ready pulse is still issued.
- A request arriving during ISSUE/RESP waits. There is no starvation: alternation is guaranteed when both are continuously asserted.
- mem_ack outside ISSUE is ignored.
- Reset asserted mid-transaction immediately returns the FSM to IDLE and clears mem_req and ready; the transaction is lost.

Optional Feature:
- Macro: REFILL_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops, the FSM goes to RESP with captured data = ERR_DATA, and timeout_err pulses high in the RESP cycle.
  - An ack in the same cycle the limit is reached takes priority, so normal data is returned and there is no error.
- Without the macro: no counter, ISSUE waits forever, and timeout_err is constant 0.

Test Plan:
- ic_miss=1, ic_addr=0x0000_1006, mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x0000_1004, ic_ready pulses once with ic_data=0xDEADBEEF, dc_ready stays 0.
- ic_miss and dc_miss asserted together from reset and held for 4 transactions → grants in order IC, DC, IC, DC; each ready pulse is exactly 1 cycle.
- dc_miss alone, mem_ack delayed 10 cycles → mem_req and mem_addr stable for all 10 cycles, busy=1 throughout, dc_ready at ack+1.
- ic_miss dropped 2 cycles after grant, then dc_miss raised → the IC transaction completes with an ic_ready pulse, then DC is served next.
- reset pulled low while in ISSUE → mem_req=0 asynchronously and state=IDLE; after release, a new ic_miss is served normally.
- With REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=4, and no mem_ack → mem_req drops after 4 cycles, the requester gets 0x00000013, and timeout_err pulses once.
